// File: rtl/voice_pac_scheduler.sv
// voice_pac_scheduler
//   Shares one phase-accumulator adder across NUM_VOICES oscillator voices.
//   A divider produces the sample tick. Each tick starts a sweep that visits
//   the voices in index order. Every enabled voice gets phase += inc, wrapped
//   modulo PHASE_MAX, and the new phase is handed downstream over valid/ready.
//
//   Optional build macro: SCHED_EMIT_SILENT_EN
//     defined   : disabled voices also emit a beat carrying phase 0, with no
//                 write-back, so every tick yields NUM_VOICES beats.
//     undefined : disabled voices are skipped silently (one cycle each).

module voice_pac_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 2,
    parameter int INC_W      = 16,
    parameter int PHASE_W    = 16,
    parameter int PHASE_MAX  = 1024,
    parameter int TICK_DIV   = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [VIDX_W-1:0]  cfg_voice,
    input  logic [INC_W-1:0]   cfg_inc,
    input  logic               cfg_en,
    input  logic               clr_overrun,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VIDX_W-1:0]  out_voice,
    output logic [PHASE_W-1:0] out_phase,
    output logic               tick_o,
    output logic               busy,
    output logic               overrun
);

    localparam int SUM_W = INC_W + PHASE_W + 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(TICK_DIV - 2);
    localparam logic [VIDX_W-1:0] VIDX_LAST = VIDX_W'(NUM_VOICES - 1);
    localparam logic [SUM_W-1:0]  PMAX_S    = SUM_W'(PHASE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // Add the increment at full width and fold back into [0, PHASE_MAX).
    // Increments are always below PHASE_MAX, so one subtraction is enough.
    function automatic logic [PHASE_W-1:0] wrap_phase(
        input logic [PHASE_W-1:0] ph,
        input logic [INC_W-1:0]   inc
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(ph) + SUM_W'(inc);
        if (s >= PMAX_S) begin
            s = s - PMAX_S;
        end else begin
            s = s;
        end
        return s[PHASE_W-1:0];
    endfunction

    // Per-voice storage
    logic [PHASE_W-1:0]    phase_r [NUM_VOICES];
    logic [INC_W-1:0]      inc_r   [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_r;

    // Divider and control
    logic [CNT_W-1:0]   div_cnt_r;
    logic               tick_r;
    state_t             state_r,     state_nx_s;
    logic [VIDX_W-1:0]  vptr_r,      vptr_nx_s;
    logic               out_valid_r, valid_nx_s;
    logic [VIDX_W-1:0]  out_voice_r, voice_nx_s;
    logic [PHASE_W-1:0] out_phase_r, phase_nx_s;
    logic               busy_r;
    logic               overrun_r;
    logic               wb_s;
    logic               kill_s;
    logic               last_s;

    assign out_valid = out_valid_r;
    assign out_voice = out_voice_r;
    assign out_phase = out_phase_r;
    assign tick_o    = tick_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

    // A disabling config write aimed at the voice being emitted cancels its write-back.
    assign kill_s = cfg_we && (cfg_voice == vptr_r) && !cfg_en;
    assign last_s = (vptr_r == VIDX_LAST);

    // Sample-tick divider; the tick pulse is registered one count ahead so it
    // is high exactly while the count sits at TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
            tick_r    <= 1'b0;
        end else begin
            if (div_cnt_r == CNT_LAST) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + CNT_W'(1);
            end
            tick_r <= (div_cnt_r == CNT_PRE);
        end
    end

    // Sweep FSM: next state and next registered outputs.
    always_comb begin
        state_nx_s = state_r;
        vptr_nx_s  = vptr_r;
        valid_nx_s = out_valid_r;
        voice_nx_s = out_voice_r;
        phase_nx_s = out_phase_r;
        wb_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick_r) begin
                    state_nx_s = ST_SCAN;
                    vptr_nx_s  = '0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (en_r[vptr_r]) begin
                    valid_nx_s = 1'b1;
                    voice_nx_s = vptr_r;
                    phase_nx_s = wrap_phase(phase_r[vptr_r], inc_r[vptr_r]);
                    state_nx_s = ST_EMIT;
                end else begin
`ifdef SCHED_EMIT_SILENT_EN
                    valid_nx_s = 1'b1;
                    voice_nx_s = vptr_r;
                    phase_nx_s = '0;
                    state_nx_s = ST_EMIT;
`else
                    if (last_s) begin
                        state_nx_s = ST_IDLE;
                        vptr_nx_s  = '0;
                    end else begin
                        state_nx_s = ST_SCAN;
                        vptr_nx_s  = vptr_r + VIDX_W'(1);
                    end
`endif
                end
            end
            ST_EMIT: begin
                if (out_valid_r && out_ready) begin
                    valid_nx_s = 1'b0;
                    wb_s       = en_r[vptr_r] && !kill_s;
                    if (last_s) begin
                        state_nx_s = ST_IDLE;
                        vptr_nx_s  = '0;
                    end else begin
                        state_nx_s = ST_SCAN;
                        vptr_nx_s  = vptr_r + VIDX_W'(1);
                    end
                end else begin
                    state_nx_s = ST_EMIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                vptr_nx_s  = '0;
                valid_nx_s = 1'b0;
            end
        endcase
    end

    // Sweep FSM state register and registered beat outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            vptr_r      <= '0;
            out_valid_r <= 1'b0;
            out_voice_r <= '0;
            out_phase_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            vptr_r      <= vptr_nx_s;
            out_valid_r <= valid_nx_s;
            out_voice_r <= voice_nx_s;
            out_phase_r <= phase_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

    // Voice table: config writes, disable-clears-phase, and handshake write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_r[i] <= '0;
                inc_r[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (cfg_we && (cfg_voice == VIDX_W'(i))) begin
                    inc_r[i] <= cfg_inc;
                    en_r[i]  <= cfg_en;
                end
                if (cfg_we && (cfg_voice == VIDX_W'(i)) && !cfg_en) begin
                    phase_r[i] <= '0;
                end else if (wb_s && (vptr_r == VIDX_W'(i))) begin
                    phase_r[i] <= out_phase_r;
                end
            end
        end
    end

    // Sticky overrun: a tick during a sweep sets it; set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (tick_r && busy_r) begin
            overrun_r <= 1'b1;
        end else if (clr_overrun) begin
            overrun_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_voice_pac_scheduler.sv
// Testbench for voice_pac_scheduler: scoreboard of expected beats produced by a
// behavioural per-tick model, drained by an independent handshake monitor.

module tb_voice_pac_scheduler;

    localparam int NV   = 4;
    localparam int VW   = 2;
    localparam int IW   = 16;
    localparam int PW   = 16;
    localparam int PMAX = 1024;
    localparam int TDIV = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [VW-1:0] cfg_voice = '0;
    logic [IW-1:0] cfg_inc = '0;
    logic          cfg_en = 1'b0;
    logic          clr_overrun = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] out_voice;
    logic [PW-1:0] out_phase;
    logic          tick_o;
    logic          busy;
    logic          overrun;

    voice_pac_scheduler #(
        .NUM_VOICES(NV), .VIDX_W(VW), .INC_W(IW), .PHASE_W(PW),
        .PHASE_MAX(PMAX), .TICK_DIV(TDIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_voice(cfg_voice),
        .cfg_inc(cfg_inc), .cfg_en(cfg_en), .clr_overrun(clr_overrun),
        .out_valid(out_valid), .out_ready(out_ready), .out_voice(out_voice),
        .out_phase(out_phase), .tick_o(tick_o), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;
    int ready_mode = 1;   // 0 random(3/4), 1 always, 2 never, 3 stall voice 2
    int skip_ticks = 0;
    bit saw_tick;

    // behavioural model: per-voice state and the queue of expected beats
    int m_ph[NV];
    int m_inc[NV];
    bit m_en[NV];
    int exp_v[$];
    int exp_p[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // One sample tick: visit voices in order, advance enabled phases mod PMAX.
    task automatic model_sweep();
        for (int v = 0; v < NV; v++) begin
            if (m_en[v]) begin
                m_ph[v] = (m_ph[v] + m_inc[v]) % PMAX;
                exp_v.push_back(v);
                exp_p.push_back(m_ph[v]);
            end else begin
`ifdef SCHED_EMIT_SILENT_EN
                exp_v.push_back(v);
                exp_p.push_back(0);
`endif
            end
        end
    endtask

    always @(posedge clk) ncyc <= rst_n ? ncyc + 1 : 0;

    // Ready driver, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                2:       out_ready = 1'b0;
                default: out_ready = !(out_valid && out_voice == 2'd2);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        bit hold = 0;
        int hv = 0;
        int hp = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_voice", out_voice, hv);
                    chk("stall_phase", out_phase, hp);
                end
                hold = 0;
                if (out_valid && out_ready) begin
                    if (exp_v.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        chk("beat_voice", out_voice, exp_v.pop_front());
                        chk("beat_phase", out_phase, exp_p.pop_front());
                    end
                end else if (out_valid) begin
                    hold = 1;
                    hv = out_voice;
                    hp = out_phase;
                end
            end
        end
    end

    // Advance one cycle; check the tick against the bench's own divider count.
    task automatic step();
        @(negedge clk);
        saw_tick = ((ncyc % TDIV) == TDIV - 1);
        chk("tick_o", tick_o, saw_tick);
        if (saw_tick) begin
            if (skip_ticks > 0) skip_ticks--;
            else model_sweep();
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Move to a quiet point of the period, well after any sweep has ended.
    task automatic wait_window();
        do step(); while ((ncyc % TDIV) != 25);
    endtask

    task automatic wait_tick();
        do step(); while (!saw_tick);
    endtask

    task automatic cfg_write(input int v, input int inc, input bit en);
        cfg_we = 1'b1; cfg_voice = VW'(v); cfg_inc = IW'(inc); cfg_en = en;
        m_inc[v] = inc;
        m_en[v]  = en;
        if (!en) m_ph[v] = 0;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        for (int v = 0; v < NV; v++) begin
            m_ph[v] = 0; m_inc[v] = 0; m_en[v] = 0;
        end
        // reset state
        #23;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_voice", out_voice, 0);
        chk("rst_out_phase", out_phase, 0);
        chk("rst_tick_o", tick_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle: ticks every TDIV cycles, no beats
        steps(85);
        chk("idle_busy", busy, 0);

        // single voice accumulating through the wrap
        wait_window();
        cfg_write(1, 100, 1'b1);
        steps(12 * TDIV);

        // four voices, restart voice 1 from zero, check first-beat latency
        wait_window();
        cfg_write(1, 20, 1'b0);
        cfg_write(0, 10, 1'b1);
        cfg_write(1, 20, 1'b1);
        cfg_write(2, 30, 1'b1);
        cfg_write(3, 40, 1'b1);
        wait_tick();
        step();
        chk("lat_t1_valid", out_valid, 0);
        chk("lat_t1_busy", busy, 1);
        step();
        chk("lat_t2_valid", out_valid, 1);
        chk("lat_t2_voice", out_voice, 0);
        steps(2 * TDIV);

        // backpressure: the tick during the stall is dropped and flagged
        wait_window();
        ready_mode = 2;
        wait_tick();
        skip_ticks = 1;
        steps(60);
        chk("bp_overrun_set", overrun, 1);
        chk("bp_valid_held", out_valid, 1);
        ready_mode = 1;
        steps(15);
        chk("bp_overrun_sticky", overrun, 1);
        chk("bp_busy_done", busy, 0);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("bp_overrun_clr", overrun, 0);
        steps(TDIV);

        // disable voice 2 while its beat is pending, then re-enable it
        wait_window();
        ready_mode = 3;
        begin
            int n = 0;
            do begin step(); n++; end while (!(out_valid && out_voice == 2'd2) && n < 200);
            chk("v2_emit_seen", (out_valid && out_voice == 2'd2), 1);
        end
        cfg_write(2, 30, 1'b0);
        steps(3);
        chk("v2_pending_valid", out_valid, 1);
        ready_mode = 1;
        steps(2 * TDIV);
        wait_window();
        cfg_write(2, 30, 1'b1);
        steps(2 * TDIV);

        // randomized configuration under random backpressure
        ready_mode = 0;
        for (int r = 0; r < 25; r++) begin
            wait_window();
            cfg_write($urandom_range(0, NV - 1), $urandom_range(1, 1000),
                      ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 1) == 1)
                cfg_write($urandom_range(0, NV - 1), $urandom_range(1, 1000),
                          ($urandom_range(0, 3) != 0));
            steps(TDIV);
        end

        // drain and confirm every expected beat was delivered
        ready_mode = 1;
        wait_window();
        chk("scoreboard_empty", exp_v.size(), 0);
        chk("final_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "time limit");
    end

endmodule
